// File: rtl/cpu_intr_pkg.sv
// Shared types and constants for the CPU interrupt sequencer.
package cpu_intr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TAKE,
      ISR,
      END
   } intr_state_e;

   typedef enum logic {
      SRC_EXT,
      SRC_TMR
   } intr_src_e;

   // mip bit positions of the two sources, for CSR-side consumers.
   localparam int MIP_MEIP_BIT = 11;
   localparam int MIP_MTIP_BIT = 7;

   // Choose the source to service when at least one is eligible.
   function automatic intr_src_e pick_src(input logic ext_first,
                                          input logic elig_ex,
                                          input logic elig_t);
      intr_src_e src;
      if (ext_first) begin
         src = elig_ex ? SRC_EXT : SRC_TMR;
      end else begin
         src = elig_t ? SRC_TMR : SRC_EXT;
      end
      return src;
   endfunction

endpackage

// File: rtl/intr_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag. A new edge in the
// same cycle as a clear keeps the flag set so the second request survives.
module intr_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic clr_i,
   output logic pend_o
);

   logic req_q;
   logic pend_q;
   logic pend_d;
   logic rise;

   assign rise   = req_i & ~req_q;
   assign pend_o = pend_q;

   // Next pending value: set wins over clear.
   always_comb begin
      pend_d = pend_q;
      if (clr_i) begin
         pend_d = 1'b0;
      end
      if (rise) begin
         pend_d = 1'b1;
      end
   end

   // Request history and pending flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         req_q  <= req_i;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/cpu_intr_ctrl.sv
// Interrupt sequencer between the IRQ sources and the CSR unit: captures
// request edges, gates them with the CSR enables, and issues the entry and
// MRET return pulses. No nesting: one ISR at a time.
module cpu_intr_ctrl
   import cpu_intr_pkg::*;
#(
   parameter bit          EXT_FIRST    = 1'b1,
   parameter int unsigned GUARD_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic mie_in,
   input  logic meie_in,
   input  logic mtie_in,
   input  logic irq_ex_req,
   input  logic irq_t_req,
   input  logic mret_ex,
   input  logic stall_IF,
   output logic intr_ex,
   output logic intr_t,
   output logic intr_end_ex,
   output logic intr_end_t,
   output logic irq_ex_ack,
   output logic irq_t_ack,
   output logic wfi_wake,
   output logic spur_mret
);

   localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

   intr_state_e state_q, state_d;
   intr_src_e   src_q,   src_d;
   logic [3:0]  guard_q, guard_d;
   logic        spur_q,  spur_d;

   logic pend_ex, pend_t;
   logic clr_ex,  clr_t;
   logic elig_ex, elig_t;

   intr_edge_latch u_latch_ex (
      .clk    (clk),
      .rst    (rst),
      .req_i  (irq_ex_req),
      .clr_i  (clr_ex),
      .pend_o (pend_ex)
   );

   intr_edge_latch u_latch_t (
      .clk    (clk),
      .rst    (rst),
      .req_i  (irq_t_req),
      .clr_i  (clr_t),
      .pend_o (pend_t)
   );

   assign elig_ex   = pend_ex & meie_in;
   assign elig_t    = pend_t  & mtie_in;
   // Wake ignores the global enable so WFI ends even with MIE clear.
   assign wfi_wake  = elig_ex | elig_t;
   assign spur_mret = spur_q;

   // Next-state, guard countdown and pulse decode.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      guard_d     = guard_q;
      spur_d      = spur_q;
      clr_ex      = 1'b0;
      clr_t       = 1'b0;
      intr_ex     = 1'b0;
      intr_t      = 1'b0;
      intr_end_ex = 1'b0;
      intr_end_t  = 1'b0;
      irq_ex_ack  = 1'b0;
      irq_t_ack   = 1'b0;

      case (state_q)
         IDLE: begin
            if (guard_q != 4'd0) begin
               guard_d = guard_q - 4'd1;
            end
            if ((guard_q == 4'd0) && mie_in && (elig_ex || elig_t)) begin
               src_d   = pick_src(EXT_FIRST, elig_ex, elig_t);
               state_d = TAKE;
            end
            if (mret_ex && !stall_IF) begin
               spur_d = 1'b1;
            end
         end
         TAKE: begin
            // Decision is committed; enables are not re-sampled here.
            if (!stall_IF) begin
               if (src_q == SRC_EXT) begin
                  intr_ex    = 1'b1;
                  irq_ex_ack = 1'b1;
                  clr_ex     = 1'b1;
               end else begin
                  intr_t    = 1'b1;
                  irq_t_ack = 1'b1;
                  clr_t     = 1'b1;
               end
               state_d = ISR;
            end
         end
         ISR: begin
            if (mret_ex && !stall_IF) begin
               state_d = END;
            end
         end
         END: begin
            if (!stall_IF) begin
               if (src_q == SRC_EXT) begin
                  intr_end_ex = 1'b1;
               end else begin
                  intr_end_t = 1'b1;
               end
               guard_d = GUARD_INIT;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, source, guard and sticky spurious-MRET registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= SRC_EXT;
         guard_q <= 4'd0;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         guard_q <= guard_d;
         spur_q  <= spur_d;
      end
   end

endmodule

// File: tb/tb_cpu_intr_ctrl.sv
// Bench for cpu_intr_ctrl: stimulus pushes expected pulses (kind, cycle)
// into a queue; a negedge monitor pops and checks whenever a pulse appears.
module tb_cpu_intr_ctrl;

   logic clk;
   logic rst;
   logic mie_in, meie_in, mtie_in;
   logic irq_ex_req, irq_t_req, mret_ex, stall_IF;
   logic intr_ex, intr_t, intr_end_ex, intr_end_t;
   logic irq_ex_ack, irq_t_ack, wfi_wake, spur_mret;

   typedef struct {
      int cyc;
      int kind; // 0 intr_ex, 1 intr_t, 2 intr_end_ex, 3 intr_end_t
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   cpu_intr_ctrl #(
      .EXT_FIRST    (1'b1),
      .GUARD_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mie_in      (mie_in),
      .meie_in     (meie_in),
      .mtie_in     (mtie_in),
      .irq_ex_req  (irq_ex_req),
      .irq_t_req   (irq_t_req),
      .mret_ex     (mret_ex),
      .stall_IF    (stall_IF),
      .intr_ex     (intr_ex),
      .intr_t      (intr_t),
      .intr_end_ex (intr_end_ex),
      .intr_end_t  (intr_end_t),
      .irq_ex_ack  (irq_ex_ack),
      .irq_t_ack   (irq_t_ack),
      .wfi_wake    (wfi_wake),
      .spur_mret   (spur_mret)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int k);
      while (cyc < k) tick();
   endtask

   task automatic push(input int c, input int k);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      exp_q.push_back(e);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_intr_ex"},     int'(intr_ex),     0);
      chk({tag, "_intr_t"},      int'(intr_t),      0);
      chk({tag, "_intr_end_ex"}, int'(intr_end_ex), 0);
      chk({tag, "_intr_end_t"},  int'(intr_end_t),  0);
      chk({tag, "_irq_ex_ack"},  int'(irq_ex_ack),  0);
      chk({tag, "_irq_t_ack"},   int'(irq_t_ack),   0);
      chk({tag, "_wfi_wake"},    int'(wfi_wake),    0);
      chk({tag, "_spur_mret"},   int'(spur_mret),   0);
   endtask

   // Monitor: pop an expectation for every pulse and check kind, cycle, acks.
   always @(negedge clk) begin
      int   npulse;
      int   kind;
      exp_t e;
      if (!rst) begin
         npulse = int'(intr_ex) + int'(intr_t) + int'(intr_end_ex) + int'(intr_end_t);
         if (npulse != 0 || irq_ex_ack || irq_t_ack) begin
            chk("ack_ex_match", int'(irq_ex_ack), int'(intr_ex));
            chk("ack_t_match",  int'(irq_t_ack),  int'(intr_t));
         end
         if (npulse != 0) begin
            chk("pulse_onehot", npulse, 1);
            chk("pulse_no_stall", int'(stall_IF), 0);
            kind = intr_ex ? 0 : intr_t ? 1 : intr_end_ex ? 2 : 3;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse at cycle %0d: got kind %0d, expected none", cyc, kind);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_kind",  kind, e.kind);
               chk("pulse_cycle", cyc,  e.cyc);
               $display("pulse kind %0d at cycle %0d (expected kind %0d cycle %0d)", kind, cyc, e.kind, e.cyc);
            end
         end
      end
   end

   initial begin
      int t, a, b, d, f, h;
      rst = 1'b1;
      mie_in = 1'b0; meie_in = 1'b0; mtie_in = 1'b0;
      irq_ex_req = 1'b0; irq_t_req = 1'b0; mret_ex = 1'b0; stall_IF = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();
      mie_in = 1'b1; meie_in = 1'b1; mtie_in = 1'b1;
      tick();

      // Single external pulse: entry two cycles after the edge, then MRET.
      t = cyc;
      irq_ex_req = 1'b1; push(t + 2, 0);
      tick();
      irq_ex_req = 1'b0;
      wait_until(t + 4);
      mret_ex = 1'b1; push(t + 5, 2);
      tick();
      mret_ex = 1'b0;
      wait_until(t + 9);

      // Both rise together: external first, timer after the guard gap.
      a = cyc;
      irq_ex_req = 1'b1; irq_t_req = 1'b1; push(a + 2, 0);
      wait_until(a + 3);
      irq_ex_req = 1'b0; irq_t_req = 1'b0;
      wait_until(a + 4);
      mret_ex = 1'b1; push(a + 5, 2);
      tick();
      mret_ex = 1'b0;
      push(a + 9, 1);
      wait_until(a + 6);
      chk("wfi_pending_t_in_guard", int'(wfi_wake), 1);
      wait_until(a + 11);
      mret_ex = 1'b1; push(a + 12, 3);
      tick();
      mret_ex = 1'b0;
      wait_until(a + 14);
      chk("wfi_after_both_served", int'(wfi_wake), 0);
      wait_until(a + 16);

      // Stall holds TAKE and END pulses.
      b = cyc;
      irq_ex_req = 1'b1; push(b + 5, 0);
      tick();
      irq_ex_req = 1'b0;
      wait_until(b + 2);
      stall_IF = 1'b1;
      wait_until(b + 5);
      stall_IF = 1'b0;
      wait_until(b + 7);
      mret_ex = 1'b1; push(b + 10, 2);
      tick();
      mret_ex = 1'b0; stall_IF = 1'b1;
      wait_until(b + 10);
      stall_IF = 1'b0;
      wait_until(b + 14);

      // Global enable off: wake asserted, no entry until enable returns.
      d = cyc;
      mie_in = 1'b0; irq_t_req = 1'b1;
      tick();
      irq_t_req = 1'b0;
      wait_until(d + 2);
      chk("wfi_with_mie_off", int'(wfi_wake), 1);
      wait_until(d + 6);
      mie_in = 1'b1; push(d + 7, 1);
      wait_until(d + 9);
      mret_ex = 1'b1; push(d + 10, 3);
      tick();
      mret_ex = 1'b0;
      wait_until(d + 12);

      // Spurious MRET: sticky flag until reset.
      f = cyc;
      chk("spur_before", int'(spur_mret), 0);
      mret_ex = 1'b1;
      tick();
      mret_ex = 1'b0;
      chk("spur_set", int'(spur_mret), 1);
      wait_until(f + 4);
      chk("spur_sticky", int'(spur_mret), 1);
      rst = 1'b1;
      tick();
      chk("spur_cleared_by_rst", int'(spur_mret), 0);
      rst = 1'b0;

      // New edge in the accept cycle keeps pending; reset in ISR drops it.
      h = cyc;
      irq_ex_req = 1'b1; push(h + 2, 0);
      tick();
      irq_ex_req = 1'b0;
      tick();
      irq_ex_req = 1'b1;
      tick();
      irq_ex_req = 1'b0;
      tick();
      chk("pend_ex_kept_set_wins", int'(wfi_wake), 1);
      rst = 1'b1;
      tick();
      chk_all_zero("rst_in_isr");
      rst = 1'b0;
      wait_until(h + 14);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
